// File: rtl/axi_apb_bridge.sv
// AXI4 to APB4 bridge: one AXI transaction at a time, one APB transfer per beat.
// APB errors and access timeouts are returned to the AXI side as SLVERR.

package axi_apb_pkg;
  localparam int unsigned ID_WIDTH   = 4;
  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic [2:0]            prot;
  } axi_ax_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;
    logic                  last;
  } axi_w_t;

  typedef struct packed {
    logic [ID_WIDTH-1:0] id;
    logic [1:0]          resp;
  } axi_b_t;

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] data;
    logic [1:0]            resp;
    logic                  last;
  } axi_r_t;

  typedef struct packed {
    axi_ax_t aw;
    logic    aw_valid;
    axi_w_t  w;
    logic    w_valid;
    logic    b_ready;
    axi_ax_t ar;
    logic    ar_valid;
    logic    r_ready;
  } axi_req_t;

  typedef struct packed {
    logic   aw_ready;
    logic   w_ready;
    axi_b_t b;
    logic   b_valid;
    logic   ar_ready;
    axi_r_t r;
    logic   r_valid;
  } axi_resp_t;
endpackage

module axi_apb_bridge #(
  parameter int unsigned ID_WIDTH = axi_apb_pkg::ID_WIDTH,
  parameter int unsigned TIMEOUT  = 256,
  parameter type axi_req_t  = axi_apb_pkg::axi_req_t,
  parameter type axi_resp_t = axi_apb_pkg::axi_resp_t
) (
  input  logic        clk,
  input  logic        rst,
  input  axi_req_t    axi_req_i,
  output axi_resp_t   axi_resp_o,
  output logic [31:0] paddr,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] pwdata,
  output logic [3:0]  pstrb,
  output logic [2:0]  pprot,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {IDLE, W_WAIT, SETUP, ACCESS, B_RESP, R_DATA} state_t;

  state_t              state_q, state_d;
  logic                prio_wr_q;
  logic [ID_WIDTH-1:0] id_q;
  logic [31:0]         addr_q;
  logic [7:0]          len_q;
  logic [7:0]          beats_q;
  logic [1:0]          burst_q;
  logic [2:0]          prot_q;
  logic                write_q;
  logic [31:0]         wdata_q;
  logic [3:0]          wstrb_q;
  logic                err_q;
  logic                beat_err_q;
  logic                last_q;
  logic [31:0]         rdata_q;
  logic [CNT_W-1:0]    cnt_q;

  logic ar_take_c, aw_take_c, timeout_c, access_done_c, beat_err_c;
  logic unused_c;

  assign unused_c = ^{axi_req_i.aw.size, axi_req_i.ar.size, axi_req_i.w.last};

  assign timeout_c     = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));
  assign access_done_c = pready | timeout_c;
  assign beat_err_c    = pready ? pslverr : 1'b1;

  // Next beat address; WRAP windows are (len+1)*4 bytes, len+1 a power of two.
  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [7:0] len,
                                            input logic [1:0] burst);
    logic [31:0] inc;
    logic [31:0] mask;
    inc  = a + 32'd4;
    mask = {22'd0, len, 2'b11};
    case (burst)
      BURST_FIXED: next_addr = a;
      BURST_WRAP:  next_addr = (a & ~mask) | (inc & mask);
      default:     next_addr = inc;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    ar_take_c  = 1'b0;
    aw_take_c  = 1'b0;
    axi_resp_o = '0;
    case (state_q)
      IDLE: begin
        ar_take_c = axi_req_i.ar_valid & (~axi_req_i.aw_valid | ~prio_wr_q);
        aw_take_c = axi_req_i.aw_valid & (~axi_req_i.ar_valid | prio_wr_q);
        if (ar_take_c)      state_d = SETUP;
        else if (aw_take_c) state_d = W_WAIT;
      end
      W_WAIT: if (axi_req_i.w_valid) state_d = SETUP;
      SETUP:  state_d = ACCESS;
      ACCESS: begin
        if (access_done_c) begin
          if (!write_q)          state_d = R_DATA;
          else if (beats_q != 0) state_d = W_WAIT;
          else                   state_d = B_RESP;
        end
      end
      R_DATA: if (axi_req_i.r_ready) state_d = last_q ? IDLE : SETUP;
      B_RESP: if (axi_req_i.b_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    axi_resp_o.ar_ready = ar_take_c;
    axi_resp_o.aw_ready = aw_take_c;
    axi_resp_o.w_ready  = (state_q == W_WAIT);
    axi_resp_o.b_valid  = (state_q == B_RESP);
    axi_resp_o.b.id     = id_q;
    axi_resp_o.b.resp   = err_q ? RESP_SLVERR : RESP_OKAY;
    axi_resp_o.r_valid  = (state_q == R_DATA);
    axi_resp_o.r.id     = id_q;
    axi_resp_o.r.data   = rdata_q;
    axi_resp_o.r.resp   = beat_err_q ? RESP_SLVERR : RESP_OKAY;
    axi_resp_o.r.last   = last_q;
  end

  // Transaction context, per-beat data and the access timeout counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_wr_q  <= 1'b0;
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      beats_q    <= '0;
      burst_q    <= '0;
      prot_q     <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      err_q      <= 1'b0;
      beat_err_q <= 1'b0;
      last_q     <= 1'b0;
      rdata_q    <= '0;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ar_take_c) begin
            prio_wr_q <= 1'b1;
            id_q      <= axi_req_i.ar.id;
            addr_q    <= axi_req_i.ar.addr;
            len_q     <= axi_req_i.ar.len;
            beats_q   <= axi_req_i.ar.len;
            burst_q   <= axi_req_i.ar.burst;
            prot_q    <= axi_req_i.ar.prot;
            write_q   <= 1'b0;
            wstrb_q   <= '0;
            err_q     <= 1'b0;
          end else if (aw_take_c) begin
            prio_wr_q <= 1'b0;
            id_q      <= axi_req_i.aw.id;
            addr_q    <= axi_req_i.aw.addr;
            len_q     <= axi_req_i.aw.len;
            beats_q   <= axi_req_i.aw.len;
            burst_q   <= axi_req_i.aw.burst;
            prot_q    <= axi_req_i.aw.prot;
            write_q   <= 1'b1;
            err_q     <= 1'b0;
          end
        end
        W_WAIT: begin
          if (axi_req_i.w_valid) begin
            wdata_q <= axi_req_i.w.data;
            wstrb_q <= axi_req_i.w.strb;
          end
        end
        SETUP: cnt_q <= '0;
        ACCESS: begin
          if (access_done_c) begin
            err_q      <= err_q | beat_err_c;
            beat_err_q <= beat_err_c;
            rdata_q    <= prdata;
            last_q     <= (beats_q == 0);
            if (beats_q != 0) begin
              beats_q <= beats_q - 8'd1;
              addr_q  <= next_addr(addr_q, len_q, burst_q);
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign psel    = (state_q == SETUP) || (state_q == ACCESS);
  assign penable = (state_q == ACCESS);
  assign paddr   = {addr_q[31:2], 2'b00};
  assign pwrite  = write_q;
  assign pwdata  = wdata_q;
  assign pstrb   = wstrb_q;
  assign pprot   = prot_q;

endmodule

// File: tb/tb_axi_apb_bridge.sv
// Bench for axi_apb_bridge: table of AXI transactions checked through APB/R/B
// scoreboards, plus hand sequences for latency, arbitration, timeout and reset.
module tb_axi_apb_bridge;
  import axi_apb_pkg::*;

  localparam int TMO_CYC = 2000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_req_t    req;
  axi_resp_t   resp;
  logic [31:0] paddr, pwdata;
  logic [31:0] prdata  = '0;
  logic        pready  = 1'b0;
  logic        pslverr = 1'b0;
  logic        psel, penable, pwrite;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;

  axi_apb_bridge #(.ID_WIDTH(4), .TIMEOUT(256)) dut (
    .clk(clk), .rst(rst), .axi_req_i(req), .axi_resp_o(resp),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [2:0]  prot;
  } apb_exp_t;

  typedef struct packed {
    logic             wr;
    logic [3:0]       id;
    logic [31:0]      addr;
    logic [7:0]       len;
    logic [1:0]       burst;
    logic [2:0]       prot;
    logic [3:0]       strb;
    logic [3:0]       err_mask;
    logic [1:0]       exp_bresp;
    logic [3:0]       ws;
    logic [3:0][31:0] exp_addr;
  } vec_t;

  apb_exp_t apb_q[$];
  axi_r_t   r_q[$];
  axi_b_t   b_q[$];
  bit       err_stim[$];

  int          checks = 0;
  int          errors = 0;
  int          wait_states = 0;
  int          acc_cnt = 0;
  bit          force_rd_en = 1'b0;
  logic [31:0] force_rd = '0;

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    return force_rd_en ? force_rd : ((a ^ 32'h5A5A_0000) + 32'h11);
  endfunction

  function automatic logic [31:0] wdata_of(input int tag, input int b);
    return 32'hCAFE_0000 | 32'(tag << 8) | 32'(b);
  endfunction

  function automatic vec_t mk(input logic wr, input logic [3:0] id, input logic [31:0] addr,
                              input logic [7:0] len, input logic [1:0] burst, input logic [2:0] prot,
                              input logic [3:0] strb, input logic [3:0] err, input logic [1:0] bresp,
                              input logic [3:0] ws, input logic [31:0] a0, input logic [31:0] a1,
                              input logic [31:0] a2, input logic [31:0] a3);
    vec_t v;
    v.wr = wr; v.id = id; v.addr = addr; v.len = len; v.burst = burst; v.prot = prot;
    v.strb = strb; v.err_mask = err; v.exp_bresp = bresp; v.ws = ws;
    v.exp_addr[0] = a0; v.exp_addr[1] = a1; v.exp_addr[2] = a2; v.exp_addr[3] = a3;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // APB slave: wait states and per-beat error come from the test; updates after each edge.
  always @(posedge clk) begin
    #1;
    if (psel && penable) begin
      pready = (acc_cnt >= wait_states);
      acc_cnt++;
    end else begin
      pready  = 1'b0;
      acc_cnt = 0;
    end
    pslverr = pready && (err_stim.size() != 0) && err_stim[0];
    prdata  = rd_model(paddr);
  end

  apb_exp_t mon_apb;
  axi_r_t   mon_r;
  axi_b_t   mon_b;

  // Monitor: at the falling edge, anything that will handshake on the next rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (psel && penable && pready) begin
        if (apb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL apb_unexpected: got addr %0h want none", paddr);
        end else begin
          mon_apb = apb_q.pop_front();
          chk("paddr", 64'(paddr), 64'(mon_apb.addr));
          chk("pwrite", 64'(pwrite), 64'(mon_apb.wr));
          if (mon_apb.wr) chk("pwdata", 64'(pwdata), 64'(mon_apb.data));
          chk("pstrb", 64'(pstrb), 64'(mon_apb.strb));
          chk("pprot", 64'(pprot), 64'(mon_apb.prot));
        end
        if (err_stim.size() != 0) void'(err_stim.pop_front());
      end
      if (resp.r_valid && req.r_ready) begin
        if (r_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL r_unexpected: got %0h want none", resp.r);
        end else begin
          mon_r = r_q.pop_front();
          chk("r_beat", 64'(resp.r), 64'(mon_r));
        end
      end
      if (resp.b_valid && req.b_ready) begin
        if (b_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_unexpected: got %0h want none", resp.b);
        end else begin
          mon_b = b_q.pop_front();
          chk("b_resp", 64'(resp.b), 64'(mon_b));
        end
      end
    end
  end

  task automatic push_read(input vec_t v);
    apb_exp_t a;
    axi_r_t   r;
    for (int b = 0; b <= int'(v.len); b++) begin
      a.addr = v.exp_addr[b]; a.wr = 1'b0; a.data = '0; a.strb = '0; a.prot = v.prot;
      apb_q.push_back(a);
      err_stim.push_back(v.err_mask[b]);
      r.id = v.id; r.data = rd_model(v.exp_addr[b]);
      r.resp = v.err_mask[b] ? 2'b10 : 2'b00; r.last = (b == int'(v.len));
      r_q.push_back(r);
    end
  endtask

  task automatic push_write(input vec_t v, input int tag);
    apb_exp_t a;
    axi_b_t   bb;
    for (int b = 0; b <= int'(v.len); b++) begin
      a.addr = v.exp_addr[b]; a.wr = 1'b1; a.data = wdata_of(tag, b);
      a.strb = v.strb; a.prot = v.prot;
      apb_q.push_back(a);
      err_stim.push_back(v.err_mask[b]);
    end
    bb.id = v.id; bb.resp = v.exp_bresp;
    b_q.push_back(bb);
  endtask

  // Tasks start and end 1 time unit after a rising edge.
  task automatic hs_wait(input int which, input string name);
    bit ok = 1'b0;
    for (int n = 0; n < TMO_CYC; n++) begin
      @(negedge clk);
      if ((which == 0 && resp.ar_ready) || (which == 1 && resp.aw_ready) ||
          (which == 2 && resp.w_ready)) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, 64'(ok), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic set_ar(input vec_t v);
    req.ar.id = v.id; req.ar.addr = v.addr; req.ar.len = v.len;
    req.ar.size = 3'd2; req.ar.burst = v.burst; req.ar.prot = v.prot;
  endtask

  task automatic set_aw(input vec_t v);
    req.aw.id = v.id; req.aw.addr = v.addr; req.aw.len = v.len;
    req.aw.size = 3'd2; req.aw.burst = v.burst; req.aw.prot = v.prot;
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb);
    req.w.data = data; req.w.strb = strb; req.w.last = 1'b0; req.w_valid = 1'b1;
    hs_wait(2, "w_handshake");
    req.w_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    bit ok = 1'b0;
    for (int n = 0; n < TMO_CYC; n++) begin
      if (apb_q.size() == 0 && r_q.size() == 0 && b_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk(name, 64'(ok), 64'd1);
  endtask

  task automatic run_vec(input vec_t v, input int tag);
    wait_states = int'(v.ws);
    if (v.wr) begin
      push_write(v, tag);
      set_aw(v); req.aw_valid = 1'b1;
      hs_wait(1, "aw_handshake");
      req.aw_valid = 1'b0;
      for (int b = 0; b <= int'(v.len); b++) send_w(wdata_of(tag, b), v.strb);
    end else begin
      push_read(v);
      set_ar(v); req.ar_valid = 1'b1;
      hs_wait(0, "ar_handshake");
      req.ar_valid = 1'b0;
    end
    drain("vec_drain");
    wait_states = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  vec_t vecs[8];
  vec_t va, vb, vc;
  int   n_acc;
  bit   seen;

  initial begin
    vecs[0] = mk(0, 4'h3, 32'h1000_0010, 8'd0, 2'b01, 3'd0, 4'h0, 4'b0000, 2'b00, 4'd0,
                 32'h1000_0010, 32'h0, 32'h0, 32'h0);
    vecs[1] = mk(1, 4'h5, 32'h1000_0000, 8'd3, 2'b01, 3'd0, 4'b0011, 4'b0000, 2'b00, 4'd1,
                 32'h1000_0000, 32'h1000_0004, 32'h1000_0008, 32'h1000_000C);
    vecs[2] = mk(1, 4'h6, 32'h2000_0040, 8'd1, 2'b01, 3'd1, 4'hF, 4'b0001, 2'b10, 4'd0,
                 32'h2000_0040, 32'h2000_0044, 32'h0, 32'h0);
    vecs[3] = mk(0, 4'h7, 32'h3000_0038, 8'd3, 2'b10, 3'd0, 4'h0, 4'b0000, 2'b00, 4'd2,
                 32'h3000_0038, 32'h3000_003C, 32'h3000_0030, 32'h3000_0034);
    vecs[4] = mk(0, 4'h8, 32'h4000_0100, 8'd2, 2'b00, 3'd2, 4'h0, 4'b0010, 2'b00, 4'd0,
                 32'h4000_0100, 32'h4000_0100, 32'h4000_0100, 32'h0);
    vecs[5] = mk(1, 4'h9, 32'h5000_000C, 8'd1, 2'b10, 3'd2, 4'b1100, 4'b0000, 2'b00, 4'd0,
                 32'h5000_000C, 32'h5000_0008, 32'h0, 32'h0);
    vecs[6] = mk(0, 4'hF, 32'h6000_0FF8, 8'd3, 2'b01, 3'd5, 4'h0, 4'b1000, 2'b00, 4'd1,
                 32'h6000_0FF8, 32'h6000_0FFC, 32'h6000_1000, 32'h6000_1004);
    vecs[7] = mk(1, 4'h2, 32'h7000_0004, 8'd0, 2'b00, 3'd7, 4'hF, 4'b0001, 2'b10, 4'd3,
                 32'h7000_0004, 32'h0, 32'h0, 32'h0);

    req = '0;
    req.r_ready = 1'b1;
    req.b_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_psel", 64'(psel), 64'd0);
    chk("rst_penable", 64'(penable), 64'd0);
    chk("rst_pwrite", 64'(pwrite), 64'd0);
    chk("rst_paddr", 64'(paddr), 64'd0);
    chk("rst_pwdata", 64'(pwdata), 64'd0);
    chk("rst_pstrb", 64'(pstrb), 64'd0);
    chk("rst_pprot", 64'(pprot), 64'd0);
    chk("rst_ar_ready", 64'(resp.ar_ready), 64'd0);
    chk("rst_aw_ready", 64'(resp.aw_ready), 64'd0);
    chk("rst_w_ready", 64'(resp.w_ready), 64'd0);
    chk("rst_b_valid", 64'(resp.b_valid), 64'd0);
    chk("rst_r_valid", 64'(resp.r_valid), 64'd0);
    @(posedge clk); #1;

    // Simultaneous AW/AR twice: read first, then write
    va = mk(0, 4'h1, 32'h8000_0000, 8'd0, 2'b01, 3'd0, 4'h0, 4'b0000, 2'b00, 4'd0,
            32'h8000_0000, 32'h0, 32'h0, 32'h0);
    vb = mk(1, 4'h2, 32'h8000_0100, 8'd0, 2'b01, 3'd0, 4'hF, 4'b0000, 2'b00, 4'd0,
            32'h8000_0100, 32'h0, 32'h0, 32'h0);
    vc = mk(0, 4'h3, 32'h8000_0200, 8'd0, 2'b01, 3'd0, 4'h0, 4'b0000, 2'b00, 4'd0,
            32'h8000_0200, 32'h0, 32'h0, 32'h0);
    push_read(va); push_write(vb, 20); push_read(vc);
    set_ar(va); set_aw(vb); req.ar_valid = 1'b1; req.aw_valid = 1'b1;
    @(negedge clk);
    chk("alt1_ar_ready", 64'(resp.ar_ready), 64'd1);
    chk("alt1_aw_ready", 64'(resp.aw_ready), 64'd0);
    @(posedge clk); #1;
    req.ar_valid = 1'b0; req.aw_valid = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < TMO_CYC; n++) begin
      if (r_q.size() == 1) begin seen = 1'b1; break; end
      @(posedge clk); #1;
    end
    chk("alt_first_read_done", 64'(seen), 64'd1);
    set_ar(vc); req.ar_valid = 1'b1; req.aw_valid = 1'b1;
    @(negedge clk);
    chk("alt2_aw_ready", 64'(resp.aw_ready), 64'd1);
    chk("alt2_ar_ready", 64'(resp.ar_ready), 64'd0);
    @(posedge clk); #1;
    req.aw_valid = 1'b0;
    send_w(wdata_of(20, 0), 4'hF);
    hs_wait(0, "alt3_ar_handshake");
    req.ar_valid = 1'b0;
    drain("alt_drain");

    // Table-driven transactions
    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Minimum read latency with fixed read data
    force_rd_en = 1'b1; force_rd = 32'hDEAD_BEEF;
    va = mk(0, 4'hA, 32'h1000_0010, 8'd0, 2'b01, 3'd0, 4'h0, 4'b0000, 2'b00, 4'd0,
            32'h1000_0010, 32'h0, 32'h0, 32'h0);
    push_read(va);
    set_ar(va); req.ar_valid = 1'b1;
    @(negedge clk);
    chk("lat_c0_ar_ready", 64'(resp.ar_ready), 64'd1);
    @(posedge clk); #1;
    req.ar_valid = 1'b0;
    @(negedge clk);
    chk("lat_c1_setup", 64'({psel, penable, resp.r_valid}), 64'b100);
    @(negedge clk);
    chk("lat_c2_access", 64'({psel, penable, resp.r_valid}), 64'b110);
    @(negedge clk);
    chk("lat_c3_r_valid", 64'({psel, resp.r_valid}), 64'b01);
    @(posedge clk); #1;
    drain("lat_drain");
    force_rd_en = 1'b0;

    // Access timeout: pready never rises
    wait_states = 100000;
    va = mk(0, 4'hC, 32'h9000_0000, 8'd0, 2'b01, 3'd0, 4'h0, 4'b0000, 2'b00, 4'd0,
            32'h9000_0000, 32'h0, 32'h0, 32'h0);
    mon_r.id = 4'hC; mon_r.data = rd_model(32'h9000_0000); mon_r.resp = 2'b10; mon_r.last = 1'b1;
    r_q.push_back(mon_r);
    set_ar(va); req.ar_valid = 1'b1;
    hs_wait(0, "tmo_ar_handshake");
    req.ar_valid = 1'b0;
    n_acc = 0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (penable) n_acc++;
      else if (n_acc > 0 && !psel) break;
    end
    chk("tmo_access_cycles", 64'(n_acc), 64'd256);
    @(posedge clk); #1;
    drain("tmo_drain");
    wait_states = 0;

    // Reset during ACCESS of a burst read, then a fresh read
    wait_states = 5;
    va = mk(0, 4'hD, 32'hB000_0000, 8'd3, 2'b01, 3'd0, 4'h0, 4'b0000, 2'b00, 4'd5,
            32'hB000_0000, 32'hB000_0004, 32'hB000_0008, 32'hB000_000C);
    set_ar(va); req.ar_valid = 1'b1;
    hs_wait(0, "rst_ar_handshake");
    req.ar_valid = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (penable) begin seen = 1'b1; break; end
    end
    chk("rst_reached_access", 64'(seen), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_psel", 64'(psel), 64'd0);
    chk("rst_mid_penable", 64'(penable), 64'd0);
    chk("rst_mid_r_valid", 64'(resp.r_valid), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_states = 0;
    err_stim.delete();
    run_vec(mk(0, 4'hE, 32'hB000_0020, 8'd1, 2'b01, 3'd0, 4'h0, 4'b0000, 2'b00, 4'd0,
               32'hB000_0020, 32'hB000_0024, 32'h0, 32'h0), 30);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
